alu_sequencer: RTL

Multi-cycle execute controller for the 16-bit ALU. Accepts one ALU-class instruction at a time over a valid/ready handshake, reads operands from the external 8×16 register file, and drives the ALU operand and selector inputs. It then writes the result back and maintains the architectural C/Z/N/O status register, applying a per-opcode flag-update mask. It sits between instruction issue and the ALU/register-file pair in the CPU datapath.

---
 rtl/alu_seq_pkg.sv | 72 +++++++
 rtl/alu_seq_fsm.sv | 75 +++++++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and decode helpers for the ALU execute sequencer.
//   opcode_e  : 5-bit ALU-class opcodes
//   state_e   : sequencer FSM states
//   flags_t   : architectural status flags {c,z,n,o}
//   instr_t   : instruction word field layout
//   flag_mask : per-opcode flag update mask
//   is_legal  : opcode legality check
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned IMM_W  = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_ADDI = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOT  = 5'd6,
    OP_INV  = 5'd7,
    OP_ROR  = 5'd8,
    OP_ROL  = 5'd9,
    OP_SHR  = 5'd10,
    OP_SHL  = 5'd11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ILL  = 3'd4
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic o;
  } flags_t;

  // imm5 overlays rs2 plus the two low bits
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [1:0]        imm_lo;
  } instr_t;

  // Which flags an opcode is allowed to update
  function automatic flags_t flag_mask(input logic [OP_W-1:0] op);
    flags_t m;
    m = flags_t'(4'b0000);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI:               m = flags_t'(4'b1111);
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INV: m = flags_t'(4'b0110);
      OP_ROR, OP_ROL, OP_SHR, OP_SHL:        m = flags_t'(4'b1110);
      default:                               m = flags_t'(4'b0000);
    endcase
    return m;
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequencer control FSM: state register, next-state decode and registered
// handshake/strobe outputs (each strobe reflects the state being entered).
//   clk, reset_n  : clock, async active-low reset
//   instr_valid   : instruction offered
//   op_legal_c    : offered opcode is legal (combinational decode)
//   state         : current state
//   accept_c      : handshake completes this cycle
//   instr_ready   : sequencer idle
//   rf_we, done, illegal : write-back / retire / reject strobes
module alu_seq_fsm
  import alu_seq_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   instr_valid,
  input  logic   op_legal_c,
  output state_e state,
  output logic   accept_c,
  output logic   instr_ready,
  output logic   rf_we,
  output logic   done,
  output logic   illegal
);

  state_e state_d;
  logic   ready_d;
  logic   we_d;
  logic   done_d;
  logic   ill_d;

  // State and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_d;
      instr_ready <= ready_d;
      rf_we       <= we_d;
      done        <= done_d;
      illegal     <= ill_d;
    end
  end

  // Next state, plus strobes decoded from the state about to be entered
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    ready_d  = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          accept_c = 1'b1;
          state_d  = op_legal_c ? ST_READ : ST_ILL;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ILL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    we_d    = (state_d == ST_WB);
    done_d  = (state_d == ST_WB) || (state_d == ST_ILL);
    ill_d   = (state_d == ST_ILL);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller between instruction issue and the external
// ALU / register file. Reads operands, drives the ALU, writes back and keeps
// the masked C/Z/N/O status register.
//   clk, reset_n              : clock, async active-low reset
//   instr/instr_valid/ready   : instruction handshake
//   rf_raddr_a/b, rf_rdata_a/b: operand reads (rs1/rs2)
//   rf_we/rf_waddr/rf_wdata   : result write-back
//   alu_a/alu_b/alu_s         : ALU operands and selector (zero outside EXEC)
//   alu_r, alu_c/z/n/o        : ALU result and flags
//   flag_c/z/n/o              : architectural status register
//   done, illegal             : retire / reject pulses
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_s,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_o,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_o,
  output logic              done,
  output logic              illegal
);

  instr_t            instr_w;
  state_e            state;
  logic              accept_c;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [IMM_W-1:0]  imm_q;
  flags_t            aflags_q;
  flags_t            flags_q;
  flags_t            mask_c;
  logic [DATA_W-1:0] opb_c;

  assign instr_w = instr_t'(instr);
  assign mask_c  = flag_mask(op_q);

  alu_seq_fsm u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .op_legal_c  (is_legal(instr_w.op)),
    .state       (state),
    .accept_c    (accept_c),
    .instr_ready (instr_ready),
    .rf_we       (rf_we),
    .done        (done),
    .illegal     (illegal)
  );

  // Second ALU operand: sign-extended immediate, carry-in for rotates, else rs2
  always_comb begin
    opb_c = rf_rdata_b;
    case (op_q)
      OP_ADDI:        opb_c = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
      OP_ROR, OP_ROL: opb_c = {{(DATA_W-1){1'b0}}, flags_q.c};
      default:        opb_c = rf_rdata_b;
    endcase
  end

  // Datapath registers; each output is loaded on entry to the state that owns it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      aflags_q   <= flags_t'(4'b0000);
      flags_q    <= flags_t'(4'b0000);
    end else begin
      if (accept_c) begin
        op_q  <= instr_w.op;
        rd_q  <= instr_w.rd;
        imm_q <= {instr_w.rs2, instr_w.imm_lo};
      end
      rf_raddr_a <= accept_c ? instr_w.rs1 : '0;
      rf_raddr_b <= accept_c ? instr_w.rs2 : '0;

      // Operands are captured leaving READ, so rd aliasing rs1/rs2 is harmless
      alu_a <= (state == ST_READ) ? rf_rdata_a : '0;
      alu_b <= (state == ST_READ) ? opb_c : '0;
      alu_s <= (state == ST_READ) ? op_q[SEL_W-1:0] : '0;

      rf_wdata <= (state == ST_EXEC) ? alu_r : '0;
      rf_waddr <= (state == ST_EXEC) ? rd_q : '0;
      if (state == ST_EXEC) begin
        aflags_q <= flags_t'({alu_c, alu_z, alu_n, alu_o});
      end

      // Masked flag commit as WB retires
      if (state == ST_WB) begin
        flags_q <= flags_t'((flags_q & ~mask_c) | (aflags_q & mask_c));
      end
    end
  end

  assign flag_c = flags_q.c;
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_o = flags_q.o;

endmodule
